sram_fifo_reader: RTL

- Read-side engine for the single-clock dual-port SRAM FIFO.
- Compares its own read pointer against the writer's pointer and drives `rdaddress` into the RAM read port.
- Absorbs the RAM's 1-cycle read latency (registered address, unregistered q) and presents words on a valid/ready stream through a 2-entry skid buffer.
- Sits between the RAM instance and the downstream consumer; the writer uses `rd_ptr` for its full check.

---
 rtl/fifo_pkg.sv | 26 ++
 rtl/sram_fifo_reader_if.sv | 11 +
 rtl/fifo_skid2.sv | 93 +++++++++
 rtl/sram_fifo_reader_chk.sv | 30 +++
 rtl/sram_fifo_reader.sv | 91 +++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the SRAM FIFO read/write engines: skid-buffer
// occupancy encoding, wrap-aware pointer distance and geometry check.
package fifo_pkg;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_state_e;

  // Distance wr - rd on pointers of pw bits (address plus wrap bit).
  function automatic logic [31:0] ptr_diff(input logic [31:0] wr,
                                           input logic [31:0] rd,
                                           input int unsigned pw);
    logic [31:0] mask;
    mask = (32'd1 << pw) - 32'd1;
    return (wr - rd) & mask;
  endfunction

  // The wrap-bit pointer scheme only works when the RAM is a power of two.
  function automatic bit depth_ok(input int unsigned addrbit,
                                  input int unsigned depth);
    return depth == (32'd1 << addrbit);
  endfunction

endpackage

// File: rtl/sram_fifo_reader_if.sv
// Valid/ready output stream of the FIFO read engine.
interface sram_fifo_reader_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] out_data;
  logic             out_vld;
  logic             out_rdy;

  modport master (output out_data, output out_vld, input out_rdy);
  modport slave  (input out_data, input out_vld, output out_rdy);
endinterface

// File: rtl/fifo_skid2.sv
// Two-entry skid buffer: captures one word per cycle into its tail and
// presents a registered head word with a registered valid.
module fifo_skid2
  import fifo_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             cap,
  input  logic [WIDTH-1:0] cap_data,
  input  logic             pop,
  output buf_state_e       bufcnt,
  output logic [WIDTH-1:0] out_data,
  output logic             out_vld
);

  buf_state_e       state_q, state_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic             out_vld_q, out_vld_d;

  // Occupancy transitions; the head always holds the oldest word.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (flush) begin
      state_d = BUF_EMPTY;
    end else begin
      case (state_q)
        BUF_EMPTY: begin
          if (cap) begin
            state_d = BUF_ONE;
            head_d  = cap_data;
          end else begin
            state_d = BUF_EMPTY;
          end
        end
        BUF_ONE: begin
          if (cap && pop) begin
            head_d = cap_data;
          end else if (cap) begin
            state_d = BUF_TWO;
            tail_d  = cap_data;
          end else if (pop) begin
            state_d = BUF_EMPTY;
          end else begin
            state_d = BUF_ONE;
          end
        end
        BUF_TWO: begin
          // A capture without a pop cannot happen: the reader withholds credit.
          if (pop) begin
            head_d = tail_q;
            if (cap) begin
              tail_d = cap_data;
            end else begin
              state_d = BUF_ONE;
            end
          end else begin
            state_d = BUF_TWO;
          end
        end
        default: begin
          state_d = BUF_EMPTY;
        end
      endcase
    end
    out_vld_d = (state_d != BUF_EMPTY);
  end

  // Buffer registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= BUF_EMPTY;
      head_q    <= {WIDTH{1'b0}};
      tail_q    <= {WIDTH{1'b0}};
      out_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      out_vld_q <= out_vld_d;
    end
  end

  assign bufcnt   = state_q;
  assign out_data = head_q;
  assign out_vld  = out_vld_q;

endmodule

// File: rtl/sram_fifo_reader_chk.sv
// Protocol checker for the FIFO read engine: pointer distance bound and
// skid-buffer overflow.
module sram_fifo_reader_chk
  import fifo_pkg::*;
#(
  parameter int ADDRBIT = 6,
  parameter int DEPTH   = 64
) (
  input logic               clk,
  input logic               rst,
  input logic [ADDRBIT:0]   wr_ptr,
  input logic [ADDRBIT:0]   rd_ptr,
  input logic [1:0]         bufcnt,
  input logic               cap,
  input logic               pop
);

  logic [ADDRBIT:0] avail_s;

  assign avail_s = (ADDRBIT+1)'(ptr_diff(32'(wr_ptr), 32'(rd_ptr), ADDRBIT + 1));

  // The writer may never run more than DEPTH words ahead, and a full buffer never captures without a pop.
  always @(posedge clk) begin
    if (!rst) begin
      a_avail: assert (int'(avail_s) <= DEPTH);
      a_skid:  assert (!((bufcnt == 2'(BUF_TWO)) && cap && !pop));
    end
  end

endmodule

// File: rtl/sram_fifo_reader.sv
// Read-side engine of the single-clock SRAM FIFO: owns the read pointer,
// issues RAM reads against a 2-word credit and streams words out.
module sram_fifo_reader
  import fifo_pkg::*;
#(
  parameter int ADDRBIT = 6,
  parameter int DEPTH   = 64,
  parameter int WIDTH   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDRBIT:0]     wr_ptr,
  input  logic                 flush,
  output logic [ADDRBIT:0]     rd_ptr,
  output logic [ADDRBIT-1:0]   rdaddress,
  input  logic [WIDTH-1:0]     ram_q,
  sram_fifo_reader_if.master   strm,
  output logic                 empty,
  output logic [ADDRBIT+1:0]   level
);

  localparam int PW = ADDRBIT + 1;
  localparam int LW = ADDRBIT + 2;

  if (!depth_ok(ADDRBIT, DEPTH)) begin : g_depth_check
    $error("sram_fifo_reader: DEPTH must equal 2**ADDRBIT");
  end

  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             inflight_q, inflight_d;
  logic [PW-1:0]    avail_s;
  logic [2:0]       credit_s;
  logic             pop_s;
  logic             issue_s;
  buf_state_e       bufcnt_s;
  logic             out_vld_s;
  logic [WIDTH-1:0] out_data_s;

  assign avail_s  = PW'(ptr_diff(32'(wr_ptr), 32'(rd_ptr_q), PW));
  assign pop_s    = out_vld_s & strm.out_rdy;
  // Words that will sit beyond the RAM after this edge if nothing new is issued.
  assign credit_s = 3'(bufcnt_s) + {2'b00, inflight_q} - {2'b00, pop_s};
  assign issue_s  = (avail_s != {PW{1'b0}}) && (credit_s < 3'd2);

  // Pointer advance and in-flight tracking; flush overrides any issue.
  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    inflight_d = 1'b0;
    if (flush) begin
      rd_ptr_d   = wr_ptr;
      inflight_d = 1'b0;
    end else if (issue_s) begin
      rd_ptr_d   = rd_ptr_q + {{(PW-1){1'b0}}, 1'b1};
      inflight_d = 1'b1;
    end else begin
      rd_ptr_d   = rd_ptr_q;
      inflight_d = 1'b0;
    end
  end

  // Read pointer and in-flight flag with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q   <= {PW{1'b0}};
      inflight_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      inflight_q <= inflight_d;
    end
  end

  fifo_skid2 #(.WIDTH(WIDTH)) u_skid (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .cap      (inflight_q),
    .cap_data (ram_q),
    .pop      (pop_s),
    .bufcnt   (bufcnt_s),
    .out_data (out_data_s),
    .out_vld  (out_vld_s)
  );

  assign rd_ptr        = rd_ptr_q;
  assign rdaddress     = rd_ptr_q[ADDRBIT-1:0];
  assign strm.out_data = out_data_s;
  assign strm.out_vld  = out_vld_s;
  assign level         = LW'(avail_s) + LW'(inflight_q) + LW'(bufcnt_s);
  assign empty         = (level == {LW{1'b0}});

endmodule
